zmips_regfile_sb: RTL

- Parametrised successor to the zMIPS dual-port register file.
- N_RD read ports, one write port, a saved-PC register and a live-PC alias at the top two addresses.
- Adds a per-register scoreboard (pending-write bits) and optional write-to-read bypass, so the decode stage can detect RAW hazards and stall.
- Sits between decode (reads and issues) and writeback (writes).

---
 rtl/zmips_rf_pkg.sv | 44 ++++
 rtl/zmips_rf_rdport.sv | 55 +++++
 rtl/zmips_regfile_sb.sv | 103 ++++++++++
 3 files changed

// File: rtl/zmips_rf_pkg.sv
// ---------------------------------------------------------------------------
// zmips_rf_pkg
// Shared helpers for the zMIPS register file with scoreboard.
//   rf_ngpr(addr_w)      number of general registers (top two indices are PC)
//   rf_idx_spc(addr_w)   index of the saved-PC register
//   rf_idx_lpc(addr_w)   index of the live-PC alias
//   rf_is_gpr(addr, w)   1 when addr selects a general register
//   rf_decode(addr, w)   classifies an address into rf_src_e
// ---------------------------------------------------------------------------
package zmips_rf_pkg;

   // Source selected by a read address.
   typedef enum logic [1:0] {
      RF_SRC_GPR = 2'd0,
      RF_SRC_SPC = 2'd1,
      RF_SRC_LPC = 2'd2
   } rf_src_e;

   function automatic int rf_ngpr(input int addr_w);
      return (1 << addr_w) - 2;
   endfunction

   function automatic int rf_idx_spc(input int addr_w);
      return rf_ngpr(addr_w);
   endfunction

   function automatic int rf_idx_lpc(input int addr_w);
      return rf_ngpr(addr_w) + 1;
   endfunction

   function automatic logic rf_is_gpr(input int addr, input int addr_w);
      return addr < rf_ngpr(addr_w);
   endfunction

   function automatic rf_src_e rf_decode(input int addr, input int addr_w);
      if (rf_is_gpr(addr, addr_w))
         return RF_SRC_GPR;
      else if (addr == rf_idx_spc(addr_w))
         return RF_SRC_SPC;
      else
         return RF_SRC_LPC;
   endfunction

endpackage

// File: rtl/zmips_rf_rdport.sv
// ---------------------------------------------------------------------------
// zmips_rf_rdport
// One combinational read port of the register file.
//   rd_addr   register index being read
//   gpr       current contents of all general registers
//   pend      pending-write bit per general register
//   wr/wr_addr/wr_data  writeback port of this cycle (forwarded when BYPASS=1)
//   pc_reg    saved PC, pc_wr/pc_val  PC capture of this cycle / live PC
//   rd_data   selected value, rd_busy  addressed GPR awaits a write
// ---------------------------------------------------------------------------
module zmips_rf_rdport
   import zmips_rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1,
   localparam int NGPR  = rf_ngpr(ADDR_W)
) (
   input  logic [ADDR_W-1:0]          rd_addr,
   input  logic [NGPR-1:0][DATA_W-1:0] gpr,
   input  logic [NGPR-1:0]            pend,
   input  logic                       wr,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [DATA_W-1:0]          pc_reg,
   input  logic                       pc_wr,
   input  logic [DATA_W-1:0]          pc_val,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_busy
);

   rf_src_e src;
   logic    wr_hit;
   logic    pc_fwd;

   assign src    = rf_decode(32'(rd_addr), ADDR_W);
   // Only meaningful in the GPR branch, where rd_addr is already a GPR index.
   assign wr_hit = (BYPASS != 0) && wr && (wr_addr == rd_addr);
   assign pc_fwd = (BYPASS != 0) && pc_wr;

   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      case (src)
         RF_SRC_GPR: begin
            rd_data = wr_hit ? wr_data : gpr[rd_addr];
            // A write retiring this cycle already satisfies the hazard.
            rd_busy = pend[rd_addr] & ~wr_hit;
         end
         RF_SRC_SPC: rd_data = pc_fwd ? pc_val : pc_reg;
         default:    rd_data = pc_val;
      endcase
   end

endmodule

// File: rtl/zmips_regfile_sb.sv
// ---------------------------------------------------------------------------
// zmips_regfile_sb
// Register file with N_RD read ports, one write port, saved/live PC aliases
// at the top two indices and a per-register pending-write scoreboard.
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_addr/rd_data     packed read addresses / combinational read data
//   rd_busy             per port: addressed GPR has a write outstanding
//   wr/wr_addr/wr_data  writeback; clears the pending bit of the target
//   iss/iss_addr        issue; marks the destination GPR pending
//   pc_val/pc_wr        live PC; capture into the saved-PC register
//   pend_cnt            number of pending bits set
// ---------------------------------------------------------------------------
module zmips_regfile_sb
   import zmips_rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int N_RD   = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_RD-1:0]          rd_busy,
   input  logic                     wr,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic [DATA_W-1:0]        pc_val,
   input  logic                     pc_wr,
   output logic [ADDR_W-1:0]        pend_cnt
);

   localparam int NGPR = rf_ngpr(ADDR_W);

   logic [NGPR-1:0][DATA_W-1:0] gpr_q;
   logic [DATA_W-1:0]           pc_reg_q;
   logic [NGPR-1:0]             pend_q;
   logic [NGPR-1:0]             pend_d;
   logic                        wr_gpr;
   logic                        iss_gpr;
   logic                        cnt_inc;
   logic                        cnt_dec;

   // Writes and issues aimed at the PC indices are dropped here.
   assign wr_gpr  = wr  && rf_is_gpr(32'(wr_addr),  ADDR_W);
   assign iss_gpr = iss && rf_is_gpr(32'(iss_addr), ADDR_W);

   // Clear first, then set: a same-cycle issue to the written register
   // belongs to a newer producer and must keep the bit set.
   always_comb begin
      pend_d = pend_q;
      if (wr_gpr)
         pend_d[wr_addr] = 1'b0;
      if (iss_gpr)
         pend_d[iss_addr] = 1'b1;
   end

   // Counter tracks real bit transitions only, so it stays equal to the
   // popcount without an adder tree over the whole vector.
   assign cnt_inc = iss_gpr && !pend_q[iss_addr];
   assign cnt_dec = wr_gpr && pend_q[wr_addr] &&
                    !(iss_gpr && (iss_addr == wr_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpr_q    <= '0;
         pc_reg_q <= '0;
         pend_q   <= '0;
         pend_cnt <= '0;
      end else begin
         if (wr_gpr)
            gpr_q[wr_addr] <= wr_data;
         if (pc_wr)
            pc_reg_q <= pc_val;
         pend_q   <= pend_d;
         pend_cnt <= pend_cnt + ADDR_W'(cnt_inc) - ADDR_W'(cnt_dec);
      end
   end

   for (genvar i = 0; i < N_RD; i++) begin : g_rd
      zmips_rf_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_rdport (
         .rd_addr (rd_addr[i*ADDR_W +: ADDR_W]),
         .gpr     (gpr_q),
         .pend    (pend_q),
         .wr      (wr),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .pc_reg  (pc_reg_q),
         .pc_wr   (pc_wr),
         .pc_val  (pc_val),
         .rd_data (rd_data[i*DATA_W +: DATA_W]),
         .rd_busy (rd_busy[i])
      );
   end

endmodule
